issue_scoreboard: RTL

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard for RV32I decode: tracks pending register writes, blocks RAW/WAW
// hazards and drains in-flight writes before serializing ops. Optional: SCOREBOARD_BYPASS_EN.
module issue_scoreboard #(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic        dec_ready_o,
    output logic        issue_o,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    output logic [31:0] pending_o,
    output logic [3:0]  inflight_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1
    } state_t;

    localparam logic [3:0] MAX_L = 4'(MAX_INFLIGHT);

    state_t      r_state;
    logic [31:1] r_pending;
    logic [3:0]  r_inflight;
    logic [15:0] r_stall_cnt;

    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_writes;
    logic        w_serial;
    logic        w_wr_eff;
    logic [31:0] w_pend_full;
    logic [31:0] w_pend_eff;
    logic [3:0]  w_infl_eff;
    logic        w_wb_hit;
    logic        w_raw;
    logic        w_waw;
    logic        w_ready;
    logic        w_issue;
    logic        w_set_any;
    logic [31:1] w_set;
    logic [31:1] w_clr;

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_writes  = 1'b0;
        w_serial  = 1'b0;
        case (opcode_i)
            7'b0110011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_writes  = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_use_rs1 = 1'b1;
                w_writes  = 1'b1;
            end
            7'b0100011, 7'b1100011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111, 7'b1101111: w_writes = 1'b1;
            7'b1110011, 7'b0001111:             w_serial = 1'b1;
            default: ;
        endcase
    end

    // x0 is never tracked, so a write to it neither pends nor counts against capacity.
    assign w_wr_eff    = w_writes && (rd_i != 5'd0);
    assign w_pend_full = {r_pending, 1'b0};
    assign w_wb_hit    = wb_valid_i && w_pend_full[wb_rd_i];

`ifdef SCOREBOARD_BYPASS_EN
    // A register retiring this cycle is already free for hazard and capacity checks.
    assign w_pend_eff = w_pend_full & ~({w_clr, 1'b0});
    assign w_infl_eff = r_inflight - {3'b000, w_wb_hit};
`else
    assign w_pend_eff = w_pend_full;
    assign w_infl_eff = r_inflight;
`endif

    assign w_raw = (w_use_rs1 && w_pend_eff[rs1_i]) || (w_use_rs2 && w_pend_eff[rs2_i]);
    assign w_waw = w_wr_eff && w_pend_eff[rd_i];

    always_comb begin
        w_ready = 1'b0;
        if (r_state == ST_RUN) begin
            if (w_serial) begin
                w_ready = (r_inflight == 4'd0);
            end else begin
                w_ready = !w_raw && !w_waw && (!w_wr_eff || (w_infl_eff < MAX_L));
            end
        end
    end

    assign w_issue   = dec_valid_i && w_ready;
    assign w_set_any = w_issue && w_wr_eff;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_bit
            assign w_set[gi] = w_set_any && (rd_i == 5'(gi));
            assign w_clr[gi] = w_wb_hit && (wb_rd_i == 5'(gi));

            // Set wins over clear so a same-cycle issue and retire of one rd keeps it pending.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pending[gi] <= 1'b0;
                end else begin
                    r_pending[gi] <= (r_pending[gi] & ~w_clr[gi]) | w_set[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_inflight  <= 4'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_inflight <= r_inflight + {3'b000, w_set_any} - {3'b000, w_wb_hit};
            if (dec_valid_i && !w_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            case (r_state)
                ST_RUN: begin
                    if (dec_valid_i && w_serial && (r_inflight != 4'd0)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_inflight == 4'd0) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign dec_ready_o = w_ready;
    assign issue_o     = w_issue;
    assign pending_o   = w_pend_full;
    assign inflight_o  = r_inflight;
    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;

endmodule
